// File: rtl/weight_buf_writer_if.sv
// Byte-stream handshake into the weight buffer writer.
// The master drives bytes with valid/last; the slave answers with ready.
interface weight_buf_writer_if #(
   parameter int BYTE_W = 8
);
   logic              s_valid;
   logic              s_ready;
   logic [BYTE_W-1:0] s_data;
   logic              s_last;

   modport master (
      output s_valid,
      output s_data,
      output s_last,
      input  s_ready
   );

   modport slave (
      input  s_valid,
      input  s_data,
      input  s_last,
      output s_ready
   );
endinterface

// File: rtl/weight_buf_writer.sv
// Packs a weight byte stream into 72-bit kernel words and writes them round-robin across the banks.
// Optional feature macro WEIGHT_WR_ZEROPAD_EN: a word cut short by s_last is zero-padded and written.
module weight_buf_writer #(
   parameter int BYTE_W       = 8,
   parameter int KERNEL_WIDTH = 9 * BYTE_W,
   parameter int NUM_BANK     = 4,
   parameter int ADDR_W       = 10,
   parameter int WCNT_W       = 12
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    i_start,
   input  logic [WCNT_W:0]         i_num_words,
   weight_buf_writer_if.slave      s,
   output logic [NUM_BANK-1:0]     o_we,
   output logic [ADDR_W-1:0]       o_addr,
   output logic [KERNEL_WIDTH-1:0] o_wdata,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err
);

   localparam int BYTES_PER_WORD = KERNEL_WIDTH / BYTE_W;
   localparam int BCNT_W         = $clog2(BYTES_PER_WORD);
   localparam int BANK_W         = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;

   localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(BYTES_PER_WORD - 1);
   localparam logic [BCNT_W-1:0] BCNT_ONE  = BCNT_W'(1);
   localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANK - 1);
   localparam logic [BANK_W-1:0] BANK_ONE  = BANK_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
   localparam logic [WCNT_W-1:0] WCNT_ONE  = WCNT_W'(1);
   localparam logic [WCNT_W:0]   NUM_ONE   = (WCNT_W + 1)'(1);
   localparam logic [WCNT_W:0]   MAX_WORDS = (WCNT_W + 1)'(NUM_BANK * (2 ** ADDR_W));

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A request larger than the buffer is saturated to its full capacity.
   function automatic logic [WCNT_W:0] clamp_words(input logic [WCNT_W:0] n);
      return (n > MAX_WORDS) ? MAX_WORDS : n;
   endfunction

   state_t                  state_q;
   logic [WCNT_W:0]         num_words_q;
   logic [WCNT_W-1:0]       word_cnt_q;
   logic [BCNT_W-1:0]       byte_cnt_q;
   logic [BANK_W-1:0]       bank_q;
   logic [ADDR_W-1:0]       addr_q;
   logic [KERNEL_WIDTH-1:0] pack_q;
   logic                    ready_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    err_q;
   logic [NUM_BANK-1:0]     we_q;
   logic [ADDR_W-1:0]       waddr_q;
   logic [KERNEL_WIDTH-1:0] wdata_q;

   logic                    accept;
   logic                    final_word;
   logic [KERNEL_WIDTH-1:0] pack_d;
   logic [NUM_BANK-1:0]     we_d;
   logic [BANK_W-1:0]       bank_d;
   logic [ADDR_W-1:0]       addr_d;
   logic [WCNT_W-1:0]       word_cnt_d;

   always_comb begin
      accept     = s.s_valid & ready_q;
      final_word = (({1'b0, word_cnt_q} + NUM_ONE) == num_words_q);
      // Bytes above byte_cnt are zero because pack_q is cleared between words.
      pack_d = pack_q;
      pack_d[byte_cnt_q * BYTE_W +: BYTE_W] = s.s_data;
      we_d         = '0;
      we_d[bank_q] = 1'b1;
      bank_d     = (bank_q == LAST_BANK) ? '0 : bank_q + BANK_ONE;
      addr_d     = (bank_q == LAST_BANK) ? addr_q + ADDR_ONE : addr_q;
      word_cnt_d = word_cnt_q + WCNT_ONE;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         num_words_q <= '0;
         word_cnt_q  <= '0;
         byte_cnt_q  <= '0;
         bank_q      <= '0;
         addr_q      <= '0;
         pack_q      <= '0;
         ready_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         we_q        <= '0;
         waddr_q     <= '0;
         wdata_q     <= '0;
      end else begin
         we_q   <= '0;
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (i_start) begin
                  num_words_q <= clamp_words(i_num_words);
                  err_q       <= (i_num_words > MAX_WORDS);
                  word_cnt_q  <= '0;
                  byte_cnt_q  <= '0;
                  bank_q      <= '0;
                  addr_q      <= '0;
                  pack_q      <= '0;
                  busy_q      <= 1'b1;
                  if (i_num_words == '0) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= ST_LOAD;
                     ready_q <= 1'b1;
                  end
               end
            end

            ST_LOAD: begin
               if (accept) begin
                  if (byte_cnt_q == LAST_BYTE) begin
                     we_q       <= we_d;
                     waddr_q    <= addr_q;
                     wdata_q    <= pack_d;
                     bank_q     <= bank_d;
                     addr_q     <= addr_d;
                     word_cnt_q <= word_cnt_d;
                     byte_cnt_q <= '0;
                     pack_q     <= '0;
                     // Stop on either the counted last word or s_last; they must agree.
                     if (final_word || s.s_last) begin
                        state_q <= ST_DONE;
                        ready_q <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= err_q | (final_word ^ s.s_last);
                     end
                  end else if (s.s_last) begin
`ifdef WEIGHT_WR_ZEROPAD_EN
                     we_q       <= we_d;
                     waddr_q    <= addr_q;
                     wdata_q    <= pack_d;
                     bank_q     <= bank_d;
                     addr_q     <= addr_d;
                     word_cnt_q <= word_cnt_d;
`endif
                     byte_cnt_q <= '0;
                     pack_q     <= '0;
                     state_q    <= ST_DONE;
                     ready_q    <= 1'b0;
                     done_q     <= 1'b1;
                     err_q      <= 1'b1;
                  end else begin
                     pack_q     <= pack_d;
                     byte_cnt_q <= byte_cnt_q + BCNT_ONE;
                  end
               end
            end

            default: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign s.s_ready = ready_q;
   assign o_we      = we_q;
   assign o_addr    = waddr_q;
   assign o_wdata   = wdata_q;
   assign o_busy    = busy_q;
   assign o_done    = done_q;
   assign o_err     = err_q;

endmodule

// File: doc/weight_buf_writer.md
Name: weight_buf_writer

Overview:
- Writer side of the 4-bank 1024x72 kernel weight buffer; the weight controller reads this buffer.
- Accepts a byte stream with a valid/ready handshake, for example from a future AXI-Stream front end.
- Packs each 9 bytes into one 72-bit kernel word and distributes words round-robin across the banks, one MAC bank per word.
- Reports busy, done and error to the layer sequencer.

Parameters:
- BYTE_W, 8, width of one weight; KERNEL_WIDTH = 9*BYTE_W.
- KERNEL_WIDTH, 72, width of one packed kernel word.
- NUM_BANK, 4, number of weight RAM banks (one per MAC).
- ADDR_W, 10, per-bank address width.
- WCNT_W, 12, word-count width; 12 = ADDR_W+2 (for NUM_BANK=4); covers NUM_BANK*2^ADDR_W = 4096 words.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  start pulse; sampled only in IDLE.
- i_num_words  in  WCNT_W+1  total kernel words to load; latched on i_start.
- s_valid  in  1  byte valid.
- s_ready  out  1  writer can accept a byte.
- s_data  in  BYTE_W  weight byte.
- s_last  in  1  final byte of the transfer.
- o_we  out  NUM_BANK  one-hot bank write enable.
- o_addr  out  ADDR_W  bank write address.
- o_wdata  out  KERNEL_WIDTH  packed kernel word.
- o_busy  out  1  transfer in progress.
- o_done  out  1  one-cycle completion pulse.
- o_err  out  1  sticky protocol error; cleared on the next accepted i_start.

Behaviour:
- Reset (async, rstn=0): state IDLE; all outputs 0; pack register, byte_cnt, bank, addr and word_cnt all 0. Reset mid-transfer aborts immediately; no further writes occur.
- FSM has three states: IDLE, LOAD, DONE.
- IDLE:
  - s_ready=0, o_busy=0.
  - i_start latches i_num_words, clears o_err and the counters, then moves to LOAD.
  - If i_num_words=0, moves directly to DONE; no writes.
- LOAD:
  - s_ready=1 (no backpressure; writes are fully pipelined). o_busy=1.
  - Each accepted byte (s_valid and s_ready) goes to pack[byte_cnt*BYTE_W +: BYTE_W]; byte 0 lands in the LSBs.
  - byte_cnt counts 0..8. On the accept at byte_cnt=8, byte_cnt wraps to 0.
  - The cycle after the 9th byte is accepted, o_we[bank]=1 for exactly one cycle, with o_addr=addr and o_wdata=the full word.
  - Otherwise o_we=0. o_addr and o_wdata hold their last values.
  - After each write, bank increments modulo NUM_BANK; addr increments when bank wraps from NUM_BANK-1 to 0.
  - Word k therefore goes to bank k mod 4, address k div 4.
- Completion: the final byte of word i_num_words-1 is accepted at cycle T.
  - T+1: write issued, state=DONE, o_done=1, s_ready=0.
  - T+2: IDLE, o_busy=0.
- s_last rules:
  - s_last on the final byte of the final word: normal completion.
  - Final byte accepted without s_last: completion as normal, o_err=1.
  - s_last earlier than the final byte: o_err=1.
    - If it lands on a 9th byte, that word is written, then DONE.
    - If it lands mid-word, handling is per the Optional Feature, then DONE.
- i_start while busy: ignored; i_num_words is not re-latched.
- s_valid outside LOAD: ignored; no state change.
- i_num_words greater than 4096: clamped to 4096 and o_err=1.

Optional Feature:
- Macro: WEIGHT_WR_ZEROPAD_EN.
- Defined: an early s_last mid-word zero-fills the remaining bytes. The padded word is written the next cycle (bank/addr advance normally), and DONE follows in the same cycle as that write.
- Undefined: the partial word is discarded, no write is issued, and DONE follows the cycle after the s_last accept.
- o_err=1 in both cases.

Test Plan:
- Reset, then i_start with i_num_words=12; stream bytes 0x00..0x6B back-to-back, s_last on byte 107.
  - Required: 12 writes, o_we sequence 0001,0010,0100,1000 repeating; o_addr 0,0,0,0,1,1,1,1,2,2,2,2.
  - Required: first o_wdata=0x080706050403020100; o_done one cycle after the last accept; o_err=0.
- Same stream with random s_valid gaps -> identical write contents and order; o_done exactly once; s_ready=0 after done.
- i_num_words=2; s_last asserted on byte 13 (mid second word).
  - Macro undefined: 1 write, o_err=1.
  - Macro defined: 2 writes, second o_wdata upper 4 bytes =0, o_err=1.
- i_num_words=1; 9 bytes with no s_last -> 1 write to bank 0 addr 0; o_done=1; o_err=1.
- Assert rstn low after byte 20 of a 12-word load -> outputs 0 immediately; no o_we pulses until a new i_start; a new load restarts at bank 0 addr 0.
- i_start with i_num_words=0 -> o_done one cycle later; no o_we; s_ready stays 0. A second i_start mid-load is ignored.
